// File: rtl/ila_refine_seq.sv
// ila_refine_seq: sequences chained instruction check windows, latches mapping mismatches and captures I/O commit data
module ila_refine_seq #(
    parameter int NUM_MAP   = 17,
    parameter int NUM_INSTR = 1,
    parameter int CNT_W     = 4,
    parameter int END_CYC   = 1,
    parameter int END2_CYC  = 2,
    parameter int MAX_CYC   = 6,
    parameter int NCH       = 1,
    parameter int DW        = 9
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 issue_i,
    input  logic [NUM_MAP-1:0]   map_eq_i,
    input  logic [NUM_MAP-1:0]   map_en_i,
    input  logic [NCH-1:0]       chan_valid_i,
    input  logic [NCH*DW-1:0]    chan_data_i,
    output logic                 start_o,
    output logic                 started_o,
    output logic [CNT_W-1:0]     cycle_cnt_o,
    output logic [2:0]           instr_idx_o,
    output logic                 iend_o,
    output logic                 compare_o,
    output logic                 ended_o,
    output logic                 ended2_o,
    output logic [NUM_MAP-1:0]   mismatch_vec_o,
    output logic                 pass_o,
    output logic [NCH*DW-1:0]    commit_data_o,
    output logic [NCH-1:0]       commit_valid_o,
    output logic [NCH-1:0]       toggle_valid_o
);

    if (END2_CYC <= END_CYC) begin : g_bad_end2
        $error("ila_refine_seq: END2_CYC must exceed END_CYC");
    end
    if (MAX_CYC >= (1 << CNT_W)) begin : g_bad_max
        $error("ila_refine_seq: MAX_CYC must fit in CNT_W bits");
    end
    if (NUM_INSTR > 8 || NUM_INSTR < 1) begin : g_bad_instr
        $error("ila_refine_seq: NUM_INSTR must be 1..8");
    end

    logic           win_end;
    logic           last_win;
    logic           chain;
    logic [NCH-1:0] prev_valid;
    logic [NCH-1:0] rise;

    assign last_win  = instr_idx_o == 3'(NUM_INSTR - 1);
    assign win_end   = started_o & (cycle_cnt_o == CNT_W'(END_CYC)) & ~ended_o;
    assign chain     = win_end & ~last_win;
    assign iend_o    = win_end & last_win;
    assign compare_o = iend_o | ended_o;
    assign pass_o    = ended_o & ~|mismatch_vec_o;
    assign rise      = chan_valid_i & ~prev_valid;

    // one-shot start on the first issue, then a sticky running flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            start_o   <= 1'b0;
            started_o <= 1'b0;
        end else begin
            start_o   <= issue_i & ~start_o & ~started_o;
            started_o <= started_o | start_o;
        end
    end

    // cycle counter with per-window reload (reload beats saturation) and window index
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cycle_cnt_o <= '0;
            instr_idx_o <= '0;
        end else if (chain) begin
            cycle_cnt_o <= '0;
            instr_idx_o <= instr_idx_o + 3'd1;
        end else if ((start_o | started_o) && cycle_cnt_o < CNT_W'(MAX_CYC)) begin
            cycle_cnt_o <= cycle_cnt_o + 1'b1;
        end
    end

    // sticky end flags and mismatch accumulation sampled only at window ends
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ended_o        <= 1'b0;
            ended2_o       <= 1'b0;
            mismatch_vec_o <= '0;
        end else begin
            ended_o        <= ended_o | iend_o;
            ended2_o       <= ended2_o | (ended_o & started_o & (cycle_cnt_o == CNT_W'(END2_CYC)));
            mismatch_vec_o <= mismatch_vec_o | (win_end ? (map_en_i & ~map_eq_i) : '0);
        end
    end

    // per-channel capture on valid rising edges plus the alternating toggle register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_valid     <= '0;
            commit_data_o  <= '0;
            commit_valid_o <= '0;
            toggle_valid_o <= '0;
        end else begin
            prev_valid     <= chan_valid_i;
            commit_valid_o <= commit_valid_o | rise;
            toggle_valid_o <= ~toggle_valid_o & chan_valid_i;
            for (int k = 0; k < NCH; k++)
                if (rise[k]) commit_data_o[k*DW +: DW] <= chan_data_i[k*DW +: DW];
        end
    end

endmodule

// File: tb/tb_ila_refine_seq.sv
// tb_ila_refine_seq: directed checks of window timing, chaining, mismatch latching, channel capture and async reset
module tb_ila_refine_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // instance A: three chained windows, 4 mappings, 2 channels
    logic        rst_a, issue_a;
    logic [3:0]  eq_a, en_a;
    logic [1:0]  valid_a;
    logic [17:0] data_a;
    logic        start_a, started_a, iend_a, compare_a, ended_a, ended2_a, pass_a;
    logic [3:0]  cnt_a, mm_a;
    logic [2:0]  idx_a;
    logic [17:0] cdata_a;
    logic [1:0]  cvalid_a, tog_a;

    ila_refine_seq #(.NUM_MAP(4), .NUM_INSTR(3), .NCH(2), .DW(9)) u_a (
        .clk(clk), .rst(rst_a), .issue_i(issue_a), .map_eq_i(eq_a), .map_en_i(en_a),
        .chan_valid_i(valid_a), .chan_data_i(data_a), .start_o(start_a), .started_o(started_a),
        .cycle_cnt_o(cnt_a), .instr_idx_o(idx_a), .iend_o(iend_a), .compare_o(compare_a),
        .ended_o(ended_a), .ended2_o(ended2_a), .mismatch_vec_o(mm_a), .pass_o(pass_a),
        .commit_data_o(cdata_a), .commit_valid_o(cvalid_a), .toggle_valid_o(tog_a)
    );

    // instance B: default parameters
    logic        rst_b, issue_b;
    logic [16:0] eq_b, en_b, mm_b;
    logic        valid_b, cvalid_b, tog_b;
    logic [8:0]  data_b, cdata_b;
    logic        start_b, started_b, iend_b, compare_b, ended_b, ended2_b, pass_b;
    logic [3:0]  cnt_b;
    logic [2:0]  idx_b;

    ila_refine_seq u_b (
        .clk(clk), .rst(rst_b), .issue_i(issue_b), .map_eq_i(eq_b), .map_en_i(en_b),
        .chan_valid_i(valid_b), .chan_data_i(data_b), .start_o(start_b), .started_o(started_b),
        .cycle_cnt_o(cnt_b), .instr_idx_o(idx_b), .iend_o(iend_b), .compare_o(compare_b),
        .ended_o(ended_b), .ended2_o(ended2_b), .mismatch_vec_o(mm_b), .pass_o(pass_b),
        .commit_data_o(cdata_b), .commit_valid_o(cvalid_b), .toggle_valid_o(tog_b)
    );

    int total = 0;
    int passed = 0;
    int starts;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_a = 0; issue_a = 0; eq_a = 0; en_a = 4'b1011; valid_a = 0; data_a = 0;
        rst_b = 0; issue_b = 0; eq_b = '1; en_b = '1; valid_b = 0; data_b = 0;
        tick(); tick();
        chk("a_rst_started", started_a, 0);
        chk("a_rst_cnt", cnt_a, 0);
        chk("a_rst_flags", {start_a, ended_a, ended2_a, pass_a, compare_a}, 0);
        chk("b_rst_cnt", cnt_b, 0);
        rst_a = 1; rst_b = 1;
        tick();

        // default timing with issue held high throughout
        issue_b = 1;
        tick();
        chk("b_t1_start", {start_b, started_b}, 2'b10);
        tick();
        chk("b_t2_started", {start_b, started_b}, 2'b01);
        chk("b_t2_cnt", cnt_b, 1);
        chk("b_t2_iend", {iend_b, compare_b, ended_b}, 3'b110);
        tick();
        chk("b_t3_ended", {iend_b, compare_b, ended_b, ended2_b}, 4'b0110);
        chk("b_t3_cnt", cnt_b, 2);
        chk("b_t3_pass", pass_b, 1);
        tick();
        chk("b_t4_cnt", cnt_b, 3);
        chk("b_t4_ended2", ended2_b, 1);
        starts = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            starts += int'(start_b);
        end
        chk("b_single_start", starts, 0);
        chk("b_saturate", cnt_b, 6);
        chk("b_idx", idx_b, 0);

        // channel 1 capture: only the rising edge captures
        valid_a = 2'b10; data_a = {9'h1A5, 9'h000};
        tick();
        chk("ch_cap1", cdata_a, {9'h1A5, 9'h000});
        chk("ch_cvalid", cvalid_a, 2'b10);
        chk("ch_tog1", tog_a, 2'b10);
        data_a = {9'h0FF, 9'h000};
        tick();
        chk("ch_hold2", cdata_a, {9'h1A5, 9'h000});
        chk("ch_tog2", tog_a, 2'b00);
        data_a = {9'h003, 9'h000};
        tick();
        chk("ch_hold3", cdata_a, {9'h1A5, 9'h000});
        chk("ch_tog3", tog_a, 2'b10);
        valid_a = 0;
        tick();
        chk("ch_tog_low", tog_a, 2'b00);
        valid_a = 2'b10; data_a = {9'h055, 9'h1FF};
        tick();
        chk("ch_recap", cdata_a, {9'h055, 9'h000});
        chk("ch_cvalid2", cvalid_a, 2'b10);
        valid_a = 0;

        // start a chained check, then reset asynchronously inside window 1
        issue_a = 1;
        tick();
        issue_a = 0;
        tick();
        tick();
        chk("rm_mm", mm_a, 4'b1011);
        chk("rm_idx", idx_a, 1);
        tick();
        chk("rm_cnt", cnt_a, 1);
        rst_a = 0;
        #2;
        chk("rm_async_core", {start_a, started_a, ended_a, ended2_a, pass_a, compare_a, iend_a}, 0);
        chk("rm_async_cnt_idx", {cnt_a, idx_a}, 0);
        chk("rm_async_mm", mm_a, 0);
        chk("rm_async_commit", {cdata_a, cvalid_a, tog_a}, 0);
        tick();
        rst_a = 1;
        tick();

        // chained mismatch run: map_eq differs only away from window ends except where set
        eq_a = 4'b0000;
        issue_a = 1;
        tick();
        issue_a = 0;
        chk("ch_t1_restart", {start_a, cnt_a, idx_a}, {1'b1, 4'd0, 3'd0});
        tick();
        chk("ch_t2", {cnt_a, idx_a, iend_a}, {4'd1, 3'd0, 1'b0});
        eq_a = 4'b0011;
        tick();
        eq_a = 4'b0000;
        chk("ch_t3_idx", {cnt_a, idx_a}, {4'd0, 3'd1});
        chk("ch_t3_mm", mm_a, 4'b1000);
        tick();
        chk("ch_t4", {cnt_a, idx_a, iend_a, ended_a}, {4'd1, 3'd1, 1'b0, 1'b0});
        eq_a = 4'b1110;
        tick();
        eq_a = 4'b0000;
        chk("ch_t5_idx", {cnt_a, idx_a}, {4'd0, 3'd2});
        chk("ch_t5_mm", mm_a, 4'b1001);
        tick();
        chk("ch_t6_iend", {iend_a, compare_a, ended_a}, 3'b110);
        eq_a = 4'b1111;
        tick();
        chk("ch_t7_ended", {iend_a, compare_a, ended_a, ended2_a}, 4'b0110);
        chk("ch_t7_mm", mm_a, 4'b1001);
        chk("ch_t7_pass", pass_a, 0);
        tick();
        chk("ch_t8_ended2", {cnt_a, ended2_a}, {4'd3, 1'b1});

        // clean run: every window equal, pass only once ended
        rst_a = 0;
        #2;
        rst_a = 1;
        eq_a = 4'b1111;
        issue_a = 1;
        tick();
        issue_a = 0;
        repeat (5) tick();
        chk("ok_t6", {iend_a, ended_a, pass_a}, 3'b100);
        tick();
        chk("ok_t7", {ended_a, pass_a, mm_a}, {1'b1, 1'b1, 4'b0000});

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
